// File: rtl/ram_pkg.sv
// Shared defaults and data types for the RAM request controller, the RAM and the bench.
package ram_pkg;
   localparam int RAM_DATA_W     = 8;
   localparam int RAM_ADDR_W     = 4;
   localparam int RAM_RESP_DEPTH = 4;

   typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
   typedef logic [RAM_DATA_W-1:0] ram_data_t;
endpackage

// File: rtl/ram_resp_fifo.sv
// First-word-fall-through response buffer; occupancy is tracked by a count register.
module ram_resp_fifo
   import ram_pkg::*;
#(
   parameter int DEPTH = RAM_RESP_DEPTH,
   parameter int WIDTH = RAM_DATA_W,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);
   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign count     = r_count;
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;
   // Empty buffer presents zero so the response bus has a defined value after reset.
   assign dout      = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/ram_req_ctrl.sv
// Turns write/read request streams into RAM strobes and returns read data in order,
// issuing a read only when a response buffer slot is already reserved for it.
module ram_req_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_W,
   parameter int ADDR_WIDTH = RAM_ADDR_W,
   parameter int RESP_DEPTH = RAM_RESP_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_req_addr,
   input  logic [DATA_WIDTH-1:0] wr_req_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_req_addr,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data
);
   localparam int OW = $clog2(RESP_DEPTH + 1);

   logic [OW-1:0]         r_outstanding;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_rd_en;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_rd_tag;
   logic                  w_collision;
   logic                  w_wr_hs;
   logic                  w_rd_hs;
   logic                  w_resp_hs;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic [OW-1:0]         w_fifo_count;

   // A same-address read waits a cycle so it reaches the RAM after the write lands.
   assign w_collision = wr_valid && rd_valid && (wr_req_addr == rd_req_addr);
   assign wr_ready    = !rst;
   assign rd_ready    = !rst && (r_outstanding < OW'(RESP_DEPTH)) && !w_collision;
   assign w_wr_hs     = wr_valid && wr_ready;
   assign w_rd_hs     = rd_valid && rd_ready;
   assign resp_valid  = !rst && !w_fifo_empty;
   assign w_resp_hs   = resp_valid && resp_ready;

   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign rd_en   = r_rd_en;
   assign rd_addr = r_rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_rd_en       <= 1'b0;
         r_rd_addr     <= '0;
         r_rd_tag      <= 1'b0;
         r_outstanding <= '0;
      end else begin
         r_wr_en  <= w_wr_hs;
         r_rd_en  <= w_rd_hs;
         r_rd_tag <= r_rd_en;
         if (w_wr_hs) begin
            r_wr_addr <= wr_req_addr;
            r_wr_data <= wr_req_data;
         end
         if (w_rd_hs) r_rd_addr <= rd_req_addr;
         case ({w_rd_hs, w_resp_hs})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   ram_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_rd_tag),
      .pop   (w_resp_hs),
      .din   (rd_data),
      .dout  (resp_data),
      .empty (w_fifo_empty),
      .full  (w_fifo_full),
      .count (w_fifo_count)
   );

   // Credits cover every buffered entry, so the buffer can never overflow.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(r_rd_tag && w_fifo_full)) else $error("response pushed into full buffer");
         assert (w_fifo_count <= r_outstanding) else $error("buffer holds more than outstanding reads");
      end
   end
endmodule
